// File: rtl/sobol_rng_pkg.sv
// Shared types and helpers for the sobol_rng generator.
package sobol_rng_pkg;

    // Widest direction word the helpers can produce; instances slice down to BITWIDTH.
    localparam int unsigned SOBOL_MAX_W = 32;

    typedef logic [SOBOL_MAX_W-1:0] dir_word_t;

    // Van der Corput direction vector k for a generator of width bw: 1 << (bw-1-k).
    function automatic dir_word_t default_dir(input int unsigned bw, input int unsigned k);
        return dir_word_t'(1) << (bw - 1 - k);
    endfunction

endpackage

// File: rtl/sobol_rng_if.sv
// Control / data bundle for sobol_rng. Optional scrambler ports appear under SOBOL_SCRAMBLE_EN.
interface sobol_rng_if
    import sobol_rng_pkg::*;
#(
    parameter int unsigned BITWIDTH    = 8,
    parameter int unsigned LOGBITWIDTH = $clog2(BITWIDTH)
);
    logic                   iEn;
    logic                   iClr;
    logic                   iDirWe;
    logic [LOGBITWIDTH-1:0] iDirAddr;
    logic [BITWIDTH-1:0]    iDirData;
`ifdef SOBOL_SCRAMBLE_EN
    logic                   iScrWe;
    logic [BITWIDTH-1:0]    iScrData;
`endif
    logic [BITWIDTH-1:0]    oRand;
    logic [LOGBITWIDTH-1:0] oIdx;
    logic                   oWrap;

`ifdef SOBOL_SCRAMBLE_EN
    modport master (output iEn, iClr, iDirWe, iDirAddr, iDirData, iScrWe, iScrData,
                    input  oRand, oIdx, oWrap);
    modport slave  (input  iEn, iClr, iDirWe, iDirAddr, iDirData, iScrWe, iScrData,
                    output oRand, oIdx, oWrap);
`else
    modport master (output iEn, iClr, iDirWe, iDirAddr, iDirData,
                    input  oRand, oIdx, oWrap);
    modport slave  (input  iEn, iClr, iDirWe, iDirAddr, iDirData,
                    output oRand, oIdx, oWrap);
`endif

endinterface

// File: rtl/sobol_rng_lsz_pe.sv
// Combinational least-significant-zero priority encoder, any width.
module lsz_pe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDXW-1:0]  o_idx_c,
    output logic             o_valid_c
);

    // Scan MSB to LSB so the lowest zero bit wins.
    always_comb begin
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!i_vec[i]) begin
                o_idx_c   = IDXW'(i);
                o_valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobol_rng.sv
// 1-D Sobol low-discrepancy generator with runtime-reloadable direction vectors.
// Optional feature macro: SOBOL_SCRAMBLE_EN (digital-shift mask on the output).
module sobol_rng
    import sobol_rng_pkg::*;
#(
    parameter int unsigned BITWIDTH    = 8,
    parameter int unsigned LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    sobol_rng_if.slave  bus
);

    typedef logic [BITWIDTH-1:0] dir_t;

    dir_t                   r_dir [BITWIDTH];
    dir_t                   r_cnt;
    dir_t                   r_acc;
    logic [LOGBITWIDTH-1:0] r_idx;
    logic                   r_wrap;

    logic [LOGBITWIDTH-1:0] w_lsz_idx;
    logic                   w_lsz_valid;
    logic                   w_addr_ok;
    dir_t                   w_dir_sel;
    dir_t                   w_cnt_nxt;
    dir_t                   w_acc_nxt;
    logic [LOGBITWIDTH-1:0] w_idx_nxt;
    logic                   w_wrap_nxt;

    lsz_pe #(
        .WIDTH (BITWIDTH),
        .IDXW  (LOGBITWIDTH)
    ) u_lsz (
        .i_vec     (r_cnt),
        .o_idx_c   (w_lsz_idx),
        .o_valid_c (w_lsz_valid)
    );

    assign w_dir_sel = r_dir[w_lsz_idx];

    // Out-of-range addresses only exist when BITWIDTH is not a power of two.
    if ((1 << LOGBITWIDTH) > BITWIDTH) begin : g_addr_chk
        assign w_addr_ok = (bus.iDirAddr < LOGBITWIDTH'(BITWIDTH));
    end else begin : g_addr_all
        assign w_addr_ok = 1'b1;
    end

    // Next-state for counter, accumulator, index and wrap pulse; clear beats step.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_acc_nxt  = r_acc;
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        if (bus.iClr) begin
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
            w_idx_nxt = '0;
        end else if (bus.iEn) begin
            if (w_lsz_valid) begin
                w_acc_nxt = r_acc ^ w_dir_sel;
                w_idx_nxt = w_lsz_idx;
                w_cnt_nxt = r_cnt + dir_t'(1);
            end else begin
                w_acc_nxt  = '0;
                w_cnt_nxt  = '0;
                w_idx_nxt  = LOGBITWIDTH'(BITWIDTH - 1);
                w_wrap_nxt = 1'b1;
            end
        end
    end

    // Sequence state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_acc  <= w_acc_nxt;
            r_idx  <= w_idx_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    // Direction table; a same-cycle step still reads the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BITWIDTH; k++) begin
                r_dir[k] <= dir_t'(default_dir(BITWIDTH, 32'(k)));
            end
        end else if (bus.iDirWe && w_addr_ok) begin
            r_dir[bus.iDirAddr] <= bus.iDirData;
        end
    end

`ifdef SOBOL_SCRAMBLE_EN
    dir_t r_scr;
    dir_t r_out;
    dir_t w_scr_nxt;

    assign w_scr_nxt = bus.iScrWe ? bus.iScrData : r_scr;

    // Scramble mask and registered digital-shifted output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scr <= '0;
            r_out <= '0;
        end else begin
            r_scr <= w_scr_nxt;
            r_out <= w_acc_nxt ^ w_scr_nxt;
        end
    end

    assign bus.oRand = r_out;
`else
    assign bus.oRand = r_acc;
`endif

    assign bus.oIdx  = r_idx;
    assign bus.oWrap = r_wrap;

endmodule
